// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory / MMIO responder.
//   - DMType access codes (same values as the CPU's ctrl_encode_def)
//   - MMIO register offsets inside the 64 KiB window
//   - STATUS bit positions
//   - access-size decode and alignment helpers
package dmem_mmio_responder_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [15:0] OFF_CYCLE_LO = 16'h0000;
  localparam logic [15:0] OFF_CYCLE_HI = 16'h0004;
  localparam logic [15:0] OFF_LED      = 16'h0008;
  localparam logic [15:0] OFF_TX       = 16'h000C;
  localparam logic [15:0] OFF_STATUS   = 16'h0010;

  localparam int ST_FULL     = 0;
  localparam int ST_MISALIGN = 1;
  localparam int ST_OOB      = 2;
  localparam int ST_OVF      = 3;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  // Unknown DMType codes fall back to a word access.
  function automatic acc_size_e acc_size(input logic [2:0] dmt);
    case (dmt)
      DM_HALF, DM_HALF_U: return SZ_HALF;
      DM_BYTE, DM_BYTE_U: return SZ_BYTE;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return a == 2'b00;
      SZ_HALF: return !a[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// CPU MEM-stage data port. master = CPU side, slave = responder side.
//   mem_w      write strobe
//   DMType_in  access type
//   Addr_in    byte address
//   Data_in    store data, right-aligned
//   Data_out   load data (combinational)
interface dmem_mmio_responder_if;
  logic        mem_w;
  logic [2:0]  DMType_in;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;

  modport master (output mem_w, DMType_in, Addr_in, Data_in, input Data_out);
  modport slave  (input mem_w, DMType_in, Addr_in, Data_in, output Data_out);
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Pointer-based synchronous FIFO feeding the console TX stream.
//   push/din   enqueue request and data
//   pop        dequeue request (ignored when empty)
//   dout       head entry, forced to 0 while empty
//   full/empty/count  occupancy
// A push while full is accepted only when a pop happens in the same cycle.
module dmem_mmio_responder_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; reset discards contents via the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-side responder for the CPU MEM stage: word-organised data RAM with
// byte/half merge on stores and extend on loads, plus an MMIO window with a
// 64-bit cycle counter, LED register, console TX FIFO and sticky STATUS flags.
//   clk, rst_n   clock, async active-low reset
//   bus          CPU data port (slave modport), Data_out combinational
//   tx_valid/tx_data/tx_ready  console byte stream (FIFO head)
//   led          LED register
//   err_irq      OR of sticky STATUS error flags
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          TXQ_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmem_mmio_responder_if.slave   bus,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [15:0]            led,
  output logic                   err_irq
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(TXQ_DEPTH) + 1;

  logic [31:0] addr, wdin, rdata;
  logic [2:0]  dmt;
  logic        mem_w;
  assign addr  = bus.Addr_in;
  assign wdin  = bus.Data_in;
  assign dmt   = bus.DMType_in;
  assign mem_w = bus.mem_w;

  // ---------------- decode ----------------
  acc_size_e   sz;
  logic        aligned, is_word, is_mmio, in_ram;
  logic [15:0] off;
  logic [AW-1:0] widx;

  assign sz      = acc_size(dmt);
  assign is_word = sz == SZ_WORD;
  assign aligned = is_aligned(sz, addr[1:0]);
  assign is_mmio = addr[31:16] == MMIO_BASE[31:16];
  assign in_ram  = !is_mmio && (addr[31:AW+2] == '0);
  assign off     = addr[15:0];
  assign widx    = addr[AW+1:2];

  // ---------------- state ----------------
  logic [31:0] ram [DEPTH_WORDS];
  logic [63:0] cycle;
  logic [3:1]  flags;             // {overflow, oob, misalign}
  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic [CW-1:0] tx_count;

  // ---------------- load path ----------------
  logic [31:0] rd_word, ram_load, mmio_rd;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_word = ram[widx];
  assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    case (dmt)
      DM_HALF:   ram_load = {{16{rd_half[15]}}, rd_half};
      DM_HALF_U: ram_load = {16'h0, rd_half};
      DM_BYTE:   ram_load = {{24{rd_byte[7]}}, rd_byte};
      DM_BYTE_U: ram_load = {24'h0, rd_byte};
      default:   ram_load = rd_word;
    endcase
  end

  always_comb begin
    case (off)
      OFF_CYCLE_LO: mmio_rd = cycle[31:0];
      OFF_CYCLE_HI: mmio_rd = cycle[63:32];
      OFF_LED:      mmio_rd = {16'h0, led};
      OFF_TX:       mmio_rd = 32'(tx_count);
      OFF_STATUS:   mmio_rd = {28'h0, flags[ST_OVF], flags[ST_OOB], flags[ST_MISALIGN], tx_full};
      default:      mmio_rd = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (aligned) begin
      if (is_mmio) begin
        if (is_word) rdata = mmio_rd;
      end else if (in_ram) begin
        rdata = ram_load;
      end
    end
  end
  assign bus.Data_out = rdata;

  // ---------------- store path ----------------
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ram_we, mmio_we;

  // Replicate the right-aligned store data across lanes; the byte enables
  // pick which lanes actually land.
  always_comb begin
    case (sz)
      SZ_BYTE: begin be = 4'b0001 << addr[1:0];         wdata = {4{wdin[7:0]}};  end
      SZ_HALF: begin be = 4'b0011 << {addr[1], 1'b0};   wdata = {2{wdin[15:0]}}; end
      default: begin be = 4'b1111;                      wdata = wdin;            end
    endcase
  end

  assign ram_we  = mem_w & aligned & in_ram;
  assign mmio_we = mem_w & aligned & is_mmio & is_word;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- MMIO side effects ----------------
  logic [3:1] st_set, st_clr;

  assign tx_push = mmio_we && off == OFF_TX;
  assign tx_pop  = tx_valid & tx_ready;
  assign st_clr  = (mmio_we && off == OFF_STATUS) ? wdin[3:1] : 3'b000;

  always_comb begin
    st_set              = '0;
    // Sub-word MMIO stores count as misaligned even when naturally aligned.
    st_set[ST_MISALIGN] = mem_w & (!aligned | (is_mmio & !is_word));
    st_set[ST_OOB]      = mem_w & aligned & !is_mmio & !in_ram;
    st_set[ST_OVF]      = tx_push & tx_full & !tx_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle <= '0;
      led   <= '0;
      flags <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (mmio_we && off == OFF_LED) led <= wdin[15:0];
      // A new set wins over a same-cycle clear.
      flags <= (flags & ~st_clr) | st_set;
    end
  end

  assign err_irq = |flags;

  // ---------------- TX FIFO ----------------
  dmem_mmio_responder_tx_fifo #(.DEPTH(TXQ_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (wdin[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );
  assign tx_valid = !tx_empty;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;
  localparam int DEPTH = 1024;
  localparam int RB    = DEPTH * 4;
  localparam int TXQ   = 8;
  localparam logic [2:0] W = 3'd0, H = 3'd1, HU = 3'd2, B = 3'd3, BU = 3'd4;
  localparam logic [31:0] CLO = 32'hFFFF_0000, CHI = 32'hFFFF_0004, LED = 32'hFFFF_0008;
  localparam logic [31:0] TX = 32'hFFFF_000C, ST = 32'hFFFF_0010, UNM = 32'hFFFF_0020;

  logic clk = 1'b0, rst_n = 1'b0, tx_ready = 1'b0;
  logic tx_valid, err_irq;
  logic [7:0] tx_data;
  logic [15:0] led;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(32'hFFFF_0000), .TXQ_DEPTH(TXQ)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .led(led), .err_irq(err_irq));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  mb [RB];
  bit          kn [RB];
  logic [7:0]  q [$];
  bit          f_mis, f_oob, f_ovf;
  logic [15:0] m_led;
  logic [63:0] cyc_m;
  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sz_of(input logic [2:0] d);
    if (d == H || d == HU) return 2;
    if (d == B || d == BU) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] d, input logic [31:0] a, output bit ok);
    int s = sz_of(d);
    logic [31:0] v = 0;
    ok = 1;
    if ((a % s) != 0) return 0;
    if (a[31:16] == 16'hFFFF) begin
      if (s != 4) return 0;
      case (a[15:0])
        16'h0000: return cyc_m[31:0];
        16'h0004: return cyc_m[63:32];
        16'h0008: return {16'h0, m_led};
        16'h000C: return 32'(q.size());
        16'h0010: return {28'h0, f_ovf, f_oob, f_mis, q.size() == TXQ};
        default:  return 0;
      endcase
    end
    if (a >= RB) return 0;
    for (int i = 0; i < s; i++) begin
      if (!kn[a+i]) ok = 0;
      v = v | (32'(mb[a+i]) << (8*i));
    end
    if (d == H && v[15]) v = v | 32'hFFFF_0000;
    if (d == B && v[7])  v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  task automatic model_edge(input bit w, input logic [2:0] d, input logic [31:0] a,
                            input logic [31:0] dat, input bit txr);
    int s = sz_of(d);
    bit pop, push = 0, smis = 0, soob = 0, sovf = 0, full_b;
    logic [3:1] clr = 0;
    pop = (q.size() != 0) && txr;
    if (w) begin
      if ((a % s) != 0) smis = 1;
      else if (a[31:16] == 16'hFFFF) begin
        if (s != 4) smis = 1;
        else case (a[15:0])
          16'h0008: m_led = dat[15:0];
          16'h000C: push = 1;
          16'h0010: clr = dat[3:1];
          default: ;
        endcase
      end else if (a < RB) begin
        for (int i = 0; i < s; i++) begin
          mb[a+i] = dat[8*i +: 8];
          kn[a+i] = 1;
        end
      end else soob = 1;
    end
    full_b = q.size() == TXQ;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full_b && !pop) sovf = 1;
      else q.push_back(dat[7:0]);
    end
    f_mis = (f_mis & !clr[1]) | smis;
    f_oob = (f_oob & !clr[2]) | soob;
    f_ovf = (f_ovf & !clr[3]) | sovf;
    cyc_m = cyc_m + 1;
  endtask

  task automatic model_reset();
    q.delete();
    f_mis = 0; f_oob = 0; f_ovf = 0;
    m_led = 0;
    cyc_m = 0;
  endtask

  // One bus cycle: called just after a posedge, returns just after the next.
  task automatic step(input bit w, input logic [2:0] d, input logic [31:0] a, input logic [31:0] dat,
                      input bit txr, input bit use_exp, input logic [31:0] exp_v, input string nm);
    bit ok;
    logic [31:0] mv;
    bus.mem_w = w; bus.DMType_in = d; bus.Addr_in = a; bus.Data_in = dat; tx_ready = txr;
    @(negedge clk);
    mv = mread(d, a, ok);
    if (use_exp) chk(nm, bus.Data_out, exp_v);
    else if (ok) chk({nm, "_rd"}, bus.Data_out, mv);
    chk({nm, "_txv"}, 32'(tx_valid), 32'(q.size() != 0));
    chk({nm, "_txd"}, 32'(tx_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({nm, "_led"}, 32'(led), 32'(m_led));
    chk({nm, "_irq"}, 32'(err_irq), 32'(f_mis | f_oob | f_ovf));
    model_edge(w, d, a, dat, txr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  d;
    logic [31:0] a;
    logic [31:0] dat;
    bit          ce;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [2:0] d, input logic [31:0] a,
                              input logic [31:0] dat, input bit ce, input logic [31:0] exp);
    vec_t v;
    v.w = w; v.d = d; v.a = a; v.dat = dat; v.ce = ce; v.exp = exp;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    model_reset();
    bus.mem_w = 0; bus.DMType_in = W; bus.Addr_in = CLO; bus.Data_in = 0;
    for (int i = 0; i < RB; i++) kn[i] = 0;

    // reset state
    #3;
    chk("rst_led", 32'(led), 0);
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_irq", 32'(err_irq), 0);
    chk("rst_cyc", bus.Data_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // ---------------- directed table ----------------
    tbl.push_back(mk(1, W,  32'h10, 32'h8899AABC, 0, 0));
    tbl.push_back(mk(1, W,  32'h04, 32'h11112222, 0, 0));
    tbl.push_back(mk(0, B,  32'h11, 0, 1, 32'hFFFFFFAA));
    tbl.push_back(mk(0, BU, 32'h11, 0, 1, 32'h000000AA));
    tbl.push_back(mk(0, H,  32'h12, 0, 1, 32'hFFFF8899));
    tbl.push_back(mk(0, HU, 32'h12, 0, 1, 32'h00008899));
    tbl.push_back(mk(1, B,  32'h13, 32'h0000005A, 0, 0));
    tbl.push_back(mk(0, W,  32'h10, 0, 1, 32'h5A99AABC));
    tbl.push_back(mk(1, H,  32'h12, 32'h00001234, 0, 0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h0));
    tbl.push_back(mk(0, W,  32'h10, 0, 1, 32'h1234AABC));
    tbl.push_back(mk(1, W,  32'h06, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, W,  32'h04, 0, 1, 32'h11112222));
    tbl.push_back(mk(0, W,  32'h06, 0, 1, 32'h0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h2));
    tbl.push_back(mk(1, W,  ST,     32'h2, 0, 0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h0));
    tbl.push_back(mk(0, H,  32'h11, 0, 1, 32'h0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h0));
    tbl.push_back(mk(1, W,  RB,     32'h12345678, 0, 0));
    tbl.push_back(mk(0, W,  RB,     0, 1, 32'h0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h4));
    tbl.push_back(mk(1, W,  ST,     32'h4, 0, 0));
    tbl.push_back(mk(1, W,  LED,    32'hABCD1234, 0, 0));
    tbl.push_back(mk(0, W,  LED,    0, 1, 32'h00001234));
    tbl.push_back(mk(0, B,  LED,    0, 1, 32'h0));
    tbl.push_back(mk(1, H,  LED,    32'h00009999, 0, 0));
    tbl.push_back(mk(0, W,  LED,    0, 1, 32'h00001234));
    tbl.push_back(mk(1, W,  UNM,    32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(0, W,  UNM,    0, 1, 32'h0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h2));
    tbl.push_back(mk(1, W,  ST,     32'hE, 0, 0));
    tbl.push_back(mk(0, W,  ST,     0, 1, 32'h0));
    foreach (tbl[i])
      step(tbl[i].w, tbl[i].d, tbl[i].a, tbl[i].dat, 1'b1, tbl[i].ce, tbl[i].exp, $sformatf("vec%0d", i));

    // ---------------- FIFO overflow then drain ----------------
    for (int i = 1; i <= 9; i++) step(1, W, TX, 32'(i), 0, 0, 0, "push");
    step(0, W, TX, 0, 0, 1, 32'd8, "tx_count_full");
    step(0, W, ST, 0, 0, 1, 32'h9, "status_full_ovf");
    for (int i = 1; i <= 8; i++) begin
      chk("drain_v", 32'(tx_valid), 1);
      chk("drain_d", 32'(tx_data), 32'(i));
      step(0, W, UNM, 0, 1, 1, 0, "drain");
    end
    chk("drained", 32'(tx_valid), 0);
    step(1, W, ST, 32'h8, 0, 0, 0, "clr_ovf");
    step(0, W, ST, 0, 0, 1, 32'h0, "status_clr");

    // ---------------- full FIFO, push + pop together ----------------
    for (int i = 0; i < 8; i++) step(1, W, TX, 32'h10 + 32'(i), 0, 0, 0, "fill");
    step(1, W, TX, 32'h18, 1, 0, 0, "push_pop_full");
    step(0, W, TX, 0, 0, 1, 32'd8, "pp_count");
    step(0, W, ST, 0, 0, 1, 32'h1, "pp_status");
    for (int i = 1; i <= 8; i++) begin
      chk("pp_drain_d", 32'(tx_data), 32'h10 + 32'(i));
      step(0, W, UNM, 0, 1, 1, 0, "pp_drain");
    end
    chk("pp_drained", 32'(tx_valid), 0);

    // ---------------- cycle counter ----------------
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 100; i++) step(0, W, CLO, 0, 0, 0, 0, "cyc");
    step(0, W, CLO, 0, 0, 1, 32'd100, "cycle_lo_100");
    force dut.cycle = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle;
    cyc_m = 64'h0000_0000_FFFF_FFFF;
    step(0, W, CLO, 0, 0, 1, 32'hFFFFFFFF, "cyc_forced");
    step(0, W, CLO, 0, 0, 1, 32'h0, "cyc_wrap_lo");
    step(0, W, CHI, 0, 0, 1, 32'h1, "cyc_wrap_hi");

    // ---------------- async reset mid-run ----------------
    step(1, W, LED, 32'h55AA, 0, 0, 0, "pre_led");
    step(1, W, TX, 32'h42, 0, 0, 0, "pre_tx");
    step(1, W, 32'h07, 0, 0, 0, 0, "pre_mis");
    bus.mem_w = 0; bus.DMType_in = W; bus.Addr_in = CLO;
    #2 rst_n = 0;
    #1;
    chk("arst_led", 32'(led), 0);
    chk("arst_txv", 32'(tx_valid), 0);
    chk("arst_txd", 32'(tx_data), 0);
    chk("arst_irq", 32'(err_irq), 0);
    chk("arst_cyc", bus.Data_out, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    step(0, W, 32'h10, 0, 0, 1, 32'h1234AABC, "ram_retained");
    step(0, W, TX, 0, 0, 1, 32'h0, "fifo_cleared");

    // ---------------- randomized ----------------
    for (int i = 0; i < 64; i++) step(1, W, 32'(i*4), $urandom, 0, 0, 0, "init");
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      logic [31:0] a;
      logic [15:0] offs [10] = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h14, 16'h1, 16'h2, 16'h3, 16'hE};
      if (r <= 5)      a = $urandom_range(0, 255);
      else if (r == 6) a = RB + $urandom_range(0, 1000);
      else             a = {16'hFFFF, offs[$urandom_range(0, 9)]};
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), a, $urandom,
           $urandom_range(0, 1), 0, 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
